// File: rtl/dram_port_arbiter.sv
// Two-port round-robin arbiter sharing one DRAM controller between the cache
// controller (port A) and a secondary bus master (port B).
module dram_port_arbiter #(
    parameter int unsigned MAX_HOLD = 4096
) (
    input  logic        Clock,
    input  logic        Reset_L,
    input  logic        SelA_L,
    input  logic        AS_A_L,
    input  logic        UDS_A_L,
    input  logic        LDS_A_L,
    input  logic        WE_A_L,
    input  logic [31:0] AddrA,
    input  logic [15:0] DataA,
    output logic        DtackA_L,
    input  logic        SelB_L,
    input  logic        AS_B_L,
    input  logic        UDS_B_L,
    input  logic        LDS_B_L,
    input  logic        WE_B_L,
    input  logic [31:0] AddrB,
    input  logic [15:0] DataB,
    output logic        DtackB_L,
    input  logic        DtackFromDram_L,
    output logic        DramSelect_L,
    output logic        AS_Dram_L,
    output logic        UDS_Dram_L,
    output logic        LDS_Dram_L,
    output logic        WE_Dram_L,
    output logic [31:0] AddrDram,
    output logic [15:0] DataDram,
    output logic        GrantA_H,
    output logic        GrantB_H,
    output logic        Timeout_H,
    output logic [1:0]  ArbState
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_GRANT_A = 2'b01,
        S_GRANT_B = 2'b10,
        S_RELEASE = 2'b11
    } state_t;

    localparam logic [15:0] HOLD_LIMIT = 16'(MAX_HOLD);

    state_t      r_state;
    logic        r_last_b;
    logic [15:0] r_hold;
    logic        r_timeout;
    logic        r_grant_a;
    logic        r_grant_b;

    logic        w_req_a;
    logic        w_req_b;
    logic [15:0] w_hold_inc;

    assign w_req_a    = !SelA_L && !AS_A_L;
    assign w_req_b    = !SelB_L && !AS_B_L;
    assign w_hold_inc = r_hold + 16'd1;

    // r_last_b resets to 1 so that A wins the first tie out of reset.
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state   <= S_IDLE;
            r_last_b  <= 1'b1;
            r_hold    <= '0;
            r_timeout <= 1'b0;
            r_grant_a <= 1'b0;
            r_grant_b <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_a && (!w_req_b || r_last_b)) begin
                        r_state   <= S_GRANT_A;
                        r_last_b  <= 1'b0;
                        r_hold    <= '0;
                        r_grant_a <= 1'b1;
                    end else if (w_req_b) begin
                        r_state   <= S_GRANT_B;
                        r_last_b  <= 1'b1;
                        r_hold    <= '0;
                        r_grant_b <= 1'b1;
                    end
                end
                S_GRANT_A, S_GRANT_B: begin
                    // Watchdog only flags; the grant is never revoked.
                    if (r_hold != HOLD_LIMIT)
                        r_hold <= w_hold_inc;
                    if (w_hold_inc >= HOLD_LIMIT)
                        r_timeout <= 1'b1;
                    if ((r_state == S_GRANT_A) ? !w_req_a : !w_req_b) begin
                        r_state   <= S_RELEASE;
                        r_grant_a <= 1'b0;
                        r_grant_b <= 1'b0;
                    end
                end
                S_RELEASE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Bus muxing is decoded from state so an async reset idles the bus at once.
    always_comb begin
        DramSelect_L = 1'b1;
        AS_Dram_L    = 1'b1;
        UDS_Dram_L   = 1'b1;
        LDS_Dram_L   = 1'b1;
        WE_Dram_L    = 1'b1;
        AddrDram     = '0;
        DataDram     = '0;
        DtackA_L     = 1'b1;
        DtackB_L     = 1'b1;
        if (r_state == S_GRANT_A) begin
            DramSelect_L = SelA_L;
            AS_Dram_L    = AS_A_L;
            UDS_Dram_L   = UDS_A_L;
            LDS_Dram_L   = LDS_A_L;
            WE_Dram_L    = WE_A_L;
            AddrDram     = AddrA;
            DataDram     = DataA;
            DtackA_L     = DtackFromDram_L;
        end else if (r_state == S_GRANT_B) begin
            DramSelect_L = SelB_L;
            AS_Dram_L    = AS_B_L;
            UDS_Dram_L   = UDS_B_L;
            LDS_Dram_L   = LDS_B_L;
            WE_Dram_L    = WE_B_L;
            AddrDram     = AddrB;
            DataDram     = DataB;
            DtackB_L     = DtackFromDram_L;
        end
    end

    assign GrantA_H  = r_grant_a;
    assign GrantB_H  = r_grant_b;
    assign Timeout_H = r_timeout;
    assign ArbState  = r_state;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter: a cycle model of owner/gap/round-robin
// is compared against the DUT every cycle, plus literal spot checks.
module tb_dram_port_arbiter;

    localparam int MAXH = 16;

    logic        Clock;
    logic        Reset_L;
    logic        SelA_L, AS_A_L, UDS_A_L, LDS_A_L, WE_A_L;
    logic [31:0] AddrA;
    logic [15:0] DataA;
    logic        DtackA_L;
    logic        SelB_L, AS_B_L, UDS_B_L, LDS_B_L, WE_B_L;
    logic [31:0] AddrB;
    logic [15:0] DataB;
    logic        DtackB_L;
    logic        DtackFromDram_L;
    logic        DramSelect_L, AS_Dram_L, UDS_Dram_L, LDS_Dram_L, WE_Dram_L;
    logic [31:0] AddrDram;
    logic [15:0] DataDram;
    logic        GrantA_H, GrantB_H, Timeout_H;
    logic [1:0]  ArbState;

    int n_cmp = 0;
    int n_err = 0;

    dram_port_arbiter #(.MAX_HOLD(MAXH)) dut (
        .Clock(Clock), .Reset_L(Reset_L),
        .SelA_L(SelA_L), .AS_A_L(AS_A_L), .UDS_A_L(UDS_A_L), .LDS_A_L(LDS_A_L),
        .WE_A_L(WE_A_L), .AddrA(AddrA), .DataA(DataA), .DtackA_L(DtackA_L),
        .SelB_L(SelB_L), .AS_B_L(AS_B_L), .UDS_B_L(UDS_B_L), .LDS_B_L(LDS_B_L),
        .WE_B_L(WE_B_L), .AddrB(AddrB), .DataB(DataB), .DtackB_L(DtackB_L),
        .DtackFromDram_L(DtackFromDram_L),
        .DramSelect_L(DramSelect_L), .AS_Dram_L(AS_Dram_L), .UDS_Dram_L(UDS_Dram_L),
        .LDS_Dram_L(LDS_Dram_L), .WE_Dram_L(WE_Dram_L),
        .AddrDram(AddrDram), .DataDram(DataDram),
        .GrantA_H(GrantA_H), .GrantB_H(GrantB_H), .Timeout_H(Timeout_H),
        .ArbState(ArbState)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: who owns the bus (0 none, 1 A, 2 B), a pending dead cycle,
    // who was served last, and how many grant cycles the owner has used.
    int m_owner = 0;
    bit m_gap   = 1'b0;
    int m_last  = 2;
    int m_hold  = 0;
    bit m_to    = 1'b0;

    wire reqA = !SelA_L && !AS_A_L;
    wire reqB = !SelB_L && !AS_B_L;

    always @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            m_owner <= 0; m_gap <= 1'b0; m_last <= 2; m_hold <= 0; m_to <= 1'b0;
        end else if (m_gap) begin
            m_gap <= 1'b0;
        end else if (m_owner == 0) begin
            if (reqA && (!reqB || m_last == 2)) begin
                m_owner <= 1; m_last <= 1; m_hold <= 0;
            end else if (reqB) begin
                m_owner <= 2; m_last <= 2; m_hold <= 0;
            end
        end else begin
            m_hold <= (m_hold + 1 > MAXH) ? MAXH : m_hold + 1;
            if (m_hold + 1 >= MAXH) m_to <= 1'b1;
            if ((m_owner == 1) ? !reqA : !reqB) begin
                m_owner <= 0; m_gap <= 1'b1;
            end
        end
    end

    always @(negedge Clock) begin
        logic [1:0]  e_state;
        logic [52:0] e_bus;
        logic [1:0]  e_dt;
        e_state = m_gap ? 2'd3 : 2'(m_owner);
        e_bus   = {5'b11111, 32'h0, 16'h0};
        e_dt    = 2'b11;
        if (!m_gap && m_owner == 1) begin
            e_bus = {SelA_L, AS_A_L, UDS_A_L, LDS_A_L, WE_A_L, AddrA, DataA};
            e_dt  = {DtackFromDram_L, 1'b1};
        end else if (!m_gap && m_owner == 2) begin
            e_bus = {SelB_L, AS_B_L, UDS_B_L, LDS_B_L, WE_B_L, AddrB, DataB};
            e_dt  = {1'b1, DtackFromDram_L};
        end
        check("cyc_state", {ArbState, GrantA_H, GrantB_H},
              {e_state, e_state == 2'd1, e_state == 2'd2});
        check("cyc_bus", {DramSelect_L, AS_Dram_L, UDS_Dram_L, LDS_Dram_L, WE_Dram_L,
                          AddrDram, DataDram}, e_bus);
        check("cyc_dtack", {DtackA_L, DtackB_L}, e_dt);
        check("cyc_timeout", Timeout_H, m_to);
    end

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic set_a(input bit on, input logic we, input logic [31:0] a, input logic [15:0] d);
        SelA_L = !on; AS_A_L = !on; UDS_A_L = !on; LDS_A_L = !on;
        WE_A_L = we; AddrA = a; DataA = d;
    endtask

    task automatic set_b(input bit on, input logic we, input logic [31:0] a, input logic [15:0] d);
        SelB_L = !on; AS_B_L = !on; UDS_B_L = !on; LDS_B_L = !on;
        WE_B_L = we; AddrB = a; DataB = d;
    endtask

    task automatic wait_grant(input int exp_port, input int exp_ticks, input string nm);
        int t;
        t = 0;
        do begin
            tick();
            t++;
        end while (!(GrantA_H || GrantB_H) && t < 10);
        check({nm, "_who"}, {GrantB_H, GrantA_H}, (exp_port == 1) ? 2'b01 : 2'b10);
        check({nm, "_lat"}, t, exp_ticks);
    endtask

    initial begin
        Reset_L = 1'b1;
        DtackFromDram_L = 1'b1;
        set_a(0, 1'b1, 32'h0, 16'h0);
        set_b(0, 1'b1, 32'h0, 16'h0);
        #1 Reset_L = 1'b0;
        #2;
        check("rst_state", {ArbState, GrantA_H, GrantB_H, Timeout_H}, 5'b00000);
        check("rst_bus", {DramSelect_L, AS_Dram_L, UDS_Dram_L, LDS_Dram_L, WE_Dram_L,
                          AddrDram}, {5'b11111, 32'h0});
        tick();
        Reset_L = 1'b1;

        // Idle with no requesters.
        repeat (10) tick();
        check("idle_bus", {DramSelect_L, AS_Dram_L, UDS_Dram_L, LDS_Dram_L, WE_Dram_L,
                           AddrDram}, {5'b11111, 32'h0});

        // Port A read at 0x100.
        set_a(1, 1'b1, 32'h0000_0100, 16'h0);
        tick();
        @(negedge Clock);
        check("a_rd_as", {AS_Dram_L, GrantA_H, ArbState}, {1'b0, 1'b1, 2'b01});
        check("a_rd_addr", AddrDram, 32'h0000_0100);
        DtackFromDram_L = 1'b0;
        #1;
        check("a_rd_dtack", {DtackA_L, DtackB_L}, 2'b01);
        tick();
        set_a(0, 1'b1, 32'h0000_0100, 16'h0);
        DtackFromDram_L = 1'b1;
        tick();
        check("a_rd_release", {ArbState, AS_Dram_L}, {2'b11, 1'b1});
        tick();
        check("a_rd_idle", ArbState, 2'b00);

        // Back-to-back ties alternate A,B,A,B; a reset first restores A priority.
        Reset_L = 1'b0;
        tick();
        Reset_L = 1'b1;
        set_a(1, 1'b1, 32'h0000_0A00, 16'h0);
        set_b(1, 1'b1, 32'h0000_0B00, 16'h0);
        for (int k = 0; k < 4; k++) begin
            int ex;
            ex = (k % 2 == 0) ? 1 : 2;
            wait_grant(ex, (k == 0) ? 1 : 2, $sformatf("tie%0d", k));
            tick();
            if (ex == 1) set_a(0, 1'b1, 32'h0000_0A00, 16'h0);
            else         set_b(0, 1'b1, 32'h0000_0B00, 16'h0);
            tick();
            if (k < 3) begin
                if (ex == 1) set_a(1, 1'b1, 32'h0000_0A00, 16'h0);
                else         set_b(1, 1'b1, 32'h0000_0B00, 16'h0);
            end else begin
                set_a(0, 1'b1, 32'h0000_0A00, 16'h0);
            end
        end
        tick();
        tick();

        // Port B write while A requests mid-transfer.
        set_b(1, 1'b0, 32'h0020_0000, 16'hBEEF);
        wait_grant(2, 1, "bwr");
        tick();
        set_a(1, 1'b1, 32'h0000_1234, 16'h5555);
        DtackFromDram_L = 1'b0;
        @(negedge Clock);
        check("bwr_bus", {AddrDram, DataDram, WE_Dram_L}, {32'h0020_0000, 16'hBEEF, 1'b0});
        check("bwr_dtack", {DtackA_L, DtackB_L}, 2'b10);
        tick();
        tick();
        set_b(0, 1'b1, 32'h0020_0000, 16'hBEEF);
        DtackFromDram_L = 1'b1;
        tick();
        check("bwr_release", ArbState, 2'b11);
        wait_grant(1, 2, "a_after_b");
        check("a_after_b_addr", AddrDram, 32'h0000_1234);
        set_a(0, 1'b1, 32'h0, 16'h0);
        repeat (3) tick();

        // Hold watchdog.
        check("to_pre", Timeout_H, 1'b0);
        set_a(1, 1'b1, 32'h0000_4000, 16'h0);
        tick();
        check("to_grant", GrantA_H, 1'b1);
        repeat (15) tick();
        check("to_15", Timeout_H, 1'b0);
        tick();
        check("to_16", {Timeout_H, GrantA_H}, 2'b11);
        repeat (3) tick();
        check("to_not_revoked", {GrantA_H, ArbState}, {1'b1, 2'b01});
        set_a(0, 1'b1, 32'h0, 16'h0);
        tick();
        tick();
        check("to_sticky", {Timeout_H, ArbState}, {1'b1, 2'b00});

        // Async reset during a B grant with Dtack active.
        set_b(1, 1'b1, 32'h0030_0000, 16'h0);
        wait_grant(2, 1, "rst_b");
        DtackFromDram_L = 1'b0;
        #1;
        check("rst_b_dtack", DtackB_L, 1'b0);
        Reset_L = 1'b0;
        #1;
        check("arst_ctl", {DramSelect_L, AS_Dram_L, UDS_Dram_L, LDS_Dram_L, WE_Dram_L,
                           DtackA_L, DtackB_L}, 7'h7f);
        check("arst_data", {AddrDram, DataDram}, 48'h0);
        check("arst_state", {ArbState, GrantA_H, GrantB_H, Timeout_H}, 5'b00000);
        tick();
        Reset_L = 1'b1;
        DtackFromDram_L = 1'b1;
        set_a(1, 1'b1, 32'h0000_0500, 16'h0);
        wait_grant(1, 1, "post_rst_tie");
        set_a(0, 1'b1, 32'h0, 16'h0);
        set_b(0, 1'b1, 32'h0, 16'h0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dram_port_arbiter.md
# dram_port_arbiter

Two-port arbiter that shares the single DRAM controller between the cache controller (port A) and a secondary bus master such as a DMA or video fetch engine (port B). It sits between both requesters and the DRAM controller's 68k-style bus interface. It grants one port at a time using round-robin priority on contention. It forwards the granted port's strobes, address and write data, and routes the DRAM controller's Dtack back only to the granted port.

## Interface
Parameters:
- MAX_HOLD, 4096: grant-cycle count at which the hold watchdog flags Timeout_H.

Ports:
- Clock  in  1  state-change clock, positive edge.
- Reset_L  in  1  asynchronous, active-low reset.
- SelA_L, AS_A_L, UDS_A_L, LDS_A_L, WE_A_L  in  1 each  port A select and bus strobes, active low.
- AddrA  in  32  port A address.
- DataA  in  16  port A write data.
- DtackA_L  out  1  Dtack to port A.
- SelB_L, AS_B_L, UDS_B_L, LDS_B_L, WE_B_L, AddrB[31:0], DataB[15:0], DtackB_L  same as port A, for port B.
- DtackFromDram_L  in  1  Dtack from the DRAM controller.
- DramSelect_L, AS_Dram_L, UDS_Dram_L, LDS_Dram_L, WE_Dram_L  out  1 each  to the DRAM controller.
- AddrDram  out  32  address to the DRAM controller.
- DataDram  out  16  write data to the DRAM controller.
- GrantA_H, GrantB_H  out  1 each  current grant, registered.
- Timeout_H  out  1  sticky watchdog flag.
- ArbState  out  2  current state, for debug.

## Operation
- Request definitions: ReqA = (SelA_L==0 && AS_A_L==0). ReqB is the same for port B.
- States: Idle=00, GrantA=01, GrantB=10, Release=11.
- Idle behaviour:
  - All DRAM controls are 1, AddrDram=0, DataDram=0, both Dtacks are 1.
  - ReqA only → GrantA. ReqB only → GrantB.
  - Both requesting → grant the port not equal to LastGrant.
  - Neither requesting → stay in Idle.
- LastGrant register: reset value B, so A wins the first tie. It is updated on the edge that enters GrantA or GrantB.
- GrantX (X = A or B):
  - DRAM outputs are driven combinationally from port X's Sel, AS, UDS, LDS, WE, Addr and Data.
  - DtackX_L = DtackFromDram_L. The other port's Dtack stays 1.
  - Stay while ReqX is 1. When ReqX goes to 0 → Release.
- Release: outputs as in Idle for exactly one cycle, then → Idle. This guarantees a deasserted gap that the DRAM controller can see between masters.
- Non-granted port: its strobes are ignored entirely and it is never acknowledged. It simply waits.
- Hold counter (16 bits):
  - Cleared on entry to any Grant state; increments each cycle in a Grant state; saturates at MAX_HOLD.
  - On reaching MAX_HOLD, set Timeout_H. The grant is NOT revoked.
  - Timeout_H clears only on reset.
- Reset (asynchronous, any state, including mid-transfer): state=Idle, LastGrant=B, Timeout_H=0, counter=0. All outputs are forced inactive at once: Sel/AS/UDS/LDS/WE/Dtack outputs = 1, AddrDram=0, DataDram=0, GrantA_H=GrantB_H=0, ArbState=00.

## Timing
- Grant latency: a request first seen high before edge n is granted at edge n. The DRAM controller sees the port's signals in the cycle after edge n.
- Dtack path: DtackFromDram_L → DtackX_L is combinational, with zero added cycles.
- End of grant: ReqX low before edge m → Release at edge m → Idle at edge m+1. The earliest next grant is at edge m+2, giving 2 dead cycles between masters.
- Requester drops in the same cycle the other port requests: the drop is handled first (Release, then Idle). The waiting port is then granted from Idle regardless of LastGrant, since it is the only requester.
- A port that re-asserts immediately after its own Release still loses to a pending other port in Idle, by round-robin.
- GrantA_H/GrantB_H are high exactly while ArbState is 01/10.

## Test plan
- Port A only: read at 0x00000100 → AS_Dram_L low one cycle after ReqA. Dram Dtack appears on DtackA_L in the same cycle, DtackB_L stays 1. On AS_A_L high: Release, then Idle.
- Simultaneous ReqA and ReqB straight out of reset → A granted first. B is granted at edge m+2 after A drops. In a repeated tie, B wins next (alternation A,B,A,B over 4 transfers).
- Port B write of 0xBEEF to 0x00200000 while A requests mid-transfer → AddrDram and DataDram track port B only. DtackA_L stays 1 until B finishes and A is granted.
- Hold ReqA for MAX_HOLD cycles (MAX_HOLD=16 in the bench) → Timeout_H rises at the 16th grant cycle, stays 1 after release, and the grant is not revoked.
- Assert Reset_L low during GrantB with DtackFromDram_L low → all outputs inactive and ArbState=00 immediately, without waiting for a clock edge. The first grant after reset goes to A on a tie.
- ReqA and ReqB both low for 10 cycles → DRAM controls remain all 1 and AddrDram=0.
